alu_op_sequencer: RTL and testbench

//  Clocked front-end that drives the 4-bit two-select-line ALU (S0/S1, A, B -> Output, carry)

---
 rtl/alu_op_sequencer.sv | 140 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Registered valid/ready front-end for a 4-bit two-select ALU: latches an op onto the ALU
// inputs, waits a settle time, captures the result into a one-deep response register.
module alu_op_sequencer #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_sel,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             alu_s0,
  output logic             alu_s1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic [1:0]       rsp_sel,
  output logic             busy,
  output logic [7:0]       op_count
);

  localparam int unsigned CNT_W      = 4;
  localparam int unsigned SETTLE_EFF = (SETTLE_CYC == 0) ? 1 :
                                       ((SETTLE_CYC > 15) ? 15 : SETTLE_CYC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_req_ready;
  logic               w_req_ready_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic               r_rsp_valid;
  logic               w_rsp_valid_nxt;
  logic [1:0]         r_alu_sel;
  logic [WIDTH-1:0]   r_alu_a;
  logic [WIDTH-1:0]   r_alu_b;
  logic [WIDTH-1:0]   r_rsp_result;
  logic               r_rsp_carry;
  logic [1:0]         r_rsp_sel;
  logic [7:0]         r_op_count;

  logic w_accept;
  logic w_slot_free;
  logic w_settled;
  logic w_capture;

  assign w_accept    = (r_state == IDLE) && req_valid && r_req_ready;
  assign w_slot_free = !r_rsp_valid || rsp_ready;
  assign w_settled   = (r_state == SETTLE) && (r_cnt == CNT_W'(1));
  assign w_capture   = (w_settled || (r_state == WAIT)) && w_slot_free;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)    w_state_nxt = SETTLE;
      SETTLE:  if (w_settled)   w_state_nxt = w_slot_free ? IDLE : WAIT;
      WAIT:    if (w_slot_free) w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  // Next values for the registered control outputs and settle counter
  always_comb begin
    w_req_ready_nxt = (r_state == IDLE) ? !w_accept : w_capture;
    w_busy_nxt      = (w_state_nxt != IDLE);
    w_rsp_valid_nxt = w_capture || (r_rsp_valid && !rsp_ready);
    w_cnt_nxt       = r_cnt;
    if (w_accept)
      w_cnt_nxt = CNT_W'(SETTLE_EFF);
    else if ((r_state == SETTLE) && (r_cnt != '0))
      w_cnt_nxt = r_cnt - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_req_ready  <= 1'b0;
      r_busy       <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_alu_sel    <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_sel    <= '0;
      r_op_count   <= '0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      if (w_accept) begin
        r_alu_sel <= req_sel;
        r_alu_a   <= req_a;
        r_alu_b   <= req_b;
      end
      if (w_capture) begin
        r_rsp_result <= alu_out;
        r_rsp_carry  <= alu_carry;
        r_rsp_sel    <= r_alu_sel;
        r_op_count   <= r_op_count + 8'd1;
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign alu_s0     = r_alu_sel[0];
  assign alu_s1     = r_alu_sel[1];
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_carry  = r_rsp_carry;
  assign rsp_sel    = r_rsp_sel;
  assign busy       = r_busy;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios on SETTLE_CYC=1 and 3 instances,
// plus a randomized run scored against an in-order transaction queue.
module tb_alu_op_sequencer;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  // SETTLE_CYC = 1 instance
  logic       req_valid, req_ready, rsp_valid, rsp_ready, alu_s0, alu_s1, alu_carry, rsp_carry, busy;
  logic [1:0] req_sel, rsp_sel;
  logic [3:0] req_a, req_b, alu_a, alu_b, alu_out, rsp_result;
  logic [7:0] op_count;

  // SETTLE_CYC = 3 instance
  logic       req_valid3, req_ready3, rsp_valid3, rsp_ready3, alu_s03, alu_s13, alu_carry3, rsp_carry3, busy3;
  logic [1:0] req_sel3, rsp_sel3;
  logic [3:0] req_a3, req_b3, alu_a3, alu_b3, alu_out3, rsp_result3;
  logic [7:0] op_count3;

  // Bench ALU: {carry,Output}
  function automatic logic [4:0] alu_ref(input logic [1:0] sel, input logic [3:0] a, input logic [3:0] b);
    case (sel)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {1'b0, a} - {1'b0, b};
      2'b10:   return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  assign {alu_carry, alu_out}   = alu_ref({alu_s1, alu_s0}, alu_a, alu_b);
  assign {alu_carry3, alu_out3} = alu_ref({alu_s13, alu_s03}, alu_a3, alu_b3);

  alu_op_sequencer #(.WIDTH(4), .SETTLE_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel), .req_a(req_a), .req_b(req_b),
    .alu_s0(alu_s0), .alu_s1(alu_s1), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_sel(rsp_sel), .busy(busy), .op_count(op_count)
  );

  alu_op_sequencer #(.WIDTH(4), .SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_sel(req_sel3), .req_a(req_a3), .req_b(req_b3),
    .alu_s0(alu_s03), .alu_s1(alu_s13), .alu_a(alu_a3), .alu_b(alu_b3),
    .alu_out(alu_out3), .alu_carry(alu_carry3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
    .rsp_carry(rsp_carry3), .rsp_sel(rsp_sel3), .busy(busy3), .op_count(op_count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({req_ready, alu_s1, alu_s0, alu_a, alu_b, rsp_valid, rsp_carry, rsp_result, rsp_sel, busy, op_count} !== 28'h0) begin
      n_err++; $display("FAIL reset_outputs: got %h expected 0",
        {req_ready, alu_s1, alu_s0, alu_a, alu_b, rsp_valid, rsp_carry, rsp_result, rsp_sel, busy, op_count});
    end
    n_vec++;
    if ({req_ready3, rsp_valid3, busy3, op_count3} !== 11'h0) begin
      n_err++; $display("FAIL reset_outputs3: got %h expected 0", {req_ready3, rsp_valid3, busy3, op_count3});
    end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 1'b0) begin n_err++; $display("FAIL ready_before_edge: got %b expected 0", req_ready); end
    @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_edge: got %b expected 1", req_ready); end
    n_vec++;
    if (req_ready3 !== 1'b1) begin n_err++; $display("FAIL ready3_after_edge: got %b expected 1", req_ready3); end
  endtask

  task automatic test_basic();
    req_valid = 1'b1; req_sel = 2'b00; req_a = 4'h5; req_b = 4'h9; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n_vec++;
    if ({alu_s1, alu_s0, alu_a, alu_b} !== {2'b00, 4'h5, 4'h9}) begin
      n_err++; $display("FAIL basic_alu_in: got %h expected %h", {alu_s1, alu_s0, alu_a, alu_b}, {2'b00, 4'h5, 4'h9});
    end
    n_vec++;
    if ({rsp_valid, req_ready, busy} !== 3'b001) begin
      n_err++; $display("FAIL basic_settling: got %b expected 001", {rsp_valid, req_ready, busy});
    end
    @(negedge clk);
    n_vec++;
    if ({rsp_valid, rsp_result, rsp_carry, rsp_sel} !== {1'b1, 4'hE, 1'b0, 2'b00}) begin
      n_err++; $display("FAIL basic_rsp: got %h expected %h", {rsp_valid, rsp_result, rsp_carry, rsp_sel}, {1'b1, 4'hE, 1'b0, 2'b00});
    end
    n_vec++;
    if ({op_count, req_ready, busy} !== {8'd1, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL basic_count: got %h expected %h", {op_count, req_ready, busy}, {8'd1, 1'b1, 1'b0});
    end
  endtask

  task automatic test_carry();
    logic [7:0] oc;
    oc = 8'd1;
    req_valid = 1'b1; req_sel = 2'b00; req_a = 4'h8; req_b = 4'h8;
    @(negedge clk);
    req_valid = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL carry_popped: got %b expected 0", rsp_valid); end
    @(negedge clk);
    n_vec++;
    if ({rsp_valid, rsp_result, rsp_carry} !== {1'b1, 4'h0, 1'b1}) begin
      n_err++; $display("FAIL carry_rsp: got %h expected %h", {rsp_valid, rsp_result, rsp_carry}, {1'b1, 4'h0, 1'b1});
    end
    n_vec++;
    if (op_count !== oc + 8'd1) begin n_err++; $display("FAIL carry_count: got %0d expected %0d", op_count, oc + 8'd1); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_sel = 2'b10; req_a = 4'h6; req_b = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({rsp_valid, rsp_result, rsp_carry, rsp_sel, req_ready} !== {1'b1, 4'h6, 1'b0, 2'b10, 1'b1}) begin
      n_err++; $display("FAIL bp_first: got %h expected %h", {rsp_valid, rsp_result, rsp_carry, rsp_sel, req_ready}, {1'b1, 4'h6, 1'b0, 2'b10, 1'b1});
    end
    req_valid = 1'b1; req_sel = 2'b11; req_a = 4'h3; req_b = 4'hC;
    @(negedge clk);
    req_valid = 1'b0;
    n_vec++;
    if ({alu_s1, alu_s0, alu_a, alu_b} !== {2'b11, 4'h3, 4'hC}) begin
      n_err++; $display("FAIL bp_alu_in: got %h expected %h", {alu_s1, alu_s0, alu_a, alu_b}, {2'b11, 4'h3, 4'hC});
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_vec++;
      if ({rsp_valid, rsp_result, rsp_sel, busy, req_ready} !== {1'b1, 4'h6, 2'b10, 1'b1, 1'b0}) begin
        n_err++; $display("FAIL bp_wait%0d: got %h expected %h", i, {rsp_valid, rsp_result, rsp_sel, busy, req_ready}, {1'b1, 4'h6, 2'b10, 1'b1, 1'b0});
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({rsp_valid, rsp_result, rsp_carry, rsp_sel, req_ready} !== {1'b1, 4'hF, 1'b0, 2'b11, 1'b1}) begin
      n_err++; $display("FAIL bp_pop_capture: got %h expected %h", {rsp_valid, rsp_result, rsp_carry, rsp_sel, req_ready}, {1'b1, 4'hF, 1'b0, 2'b11, 1'b1});
    end
    @(negedge clk);
    n_vec++;
    if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_settle3();
    rsp_ready3 = 1'b1;
    req_valid3 = 1'b1; req_sel3 = 2'b01; req_a3 = 4'h3; req_b3 = 4'h5;
    @(negedge clk);
    req_a3 = 4'hF;
    n_vec++;
    if ({rsp_valid3, alu_a3} !== {1'b0, 4'h3}) begin
      n_err++; $display("FAIL s3_t0: got %h expected %h", {rsp_valid3, alu_a3}, {1'b0, 4'h3});
    end
    @(negedge clk);
    req_valid3 = 1'b0;
    for (int k = 1; k < 3; k++) begin
      n_vec++;
      if ({rsp_valid3, alu_a3} !== {1'b0, 4'h3}) begin
        n_err++; $display("FAIL s3_settle%0d: got %h expected %h", k, {rsp_valid3, alu_a3}, {1'b0, 4'h3});
      end
      @(negedge clk);
    end
    n_vec++;
    if ({rsp_valid3, rsp_result3, rsp_carry3, rsp_sel3} !== {1'b1, 4'hE, 1'b1, 2'b01}) begin
      n_err++; $display("FAIL s3_rsp: got %h expected %h", {rsp_valid3, rsp_result3, rsp_carry3, rsp_sel3}, {1'b1, 4'hE, 1'b1, 2'b01});
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if ({op_count3, busy3, rsp_valid3, alu_a3} !== {8'd1, 1'b0, 1'b0, 4'h3}) begin
      n_err++; $display("FAIL s3_extra_ignored: got %h expected %h", {op_count3, busy3, rsp_valid3, alu_a3}, {8'd1, 1'b0, 1'b0, 4'h3});
    end
  endtask

  task automatic test_reset_mid();
    req_valid3 = 1'b1; req_sel3 = 2'b00; req_a3 = 4'h1; req_b3 = 4'h2;
    @(negedge clk);
    req_valid3 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({rsp_valid3, busy3, req_ready3, alu_a3, op_count3} !== 15'h0) begin
      n_err++; $display("FAIL midrst_clear: got %h expected 0", {rsp_valid3, busy3, req_ready3, alu_a3, op_count3});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++;
    if ({rsp_valid3, op_count3, busy3} !== 10'h0) begin
      n_err++; $display("FAIL midrst_no_rsp: got %h expected 0", {rsp_valid3, op_count3, busy3});
    end
  endtask

  // 256 random ops, in-order scoreboard; op_count must wrap back to 0
  task automatic test_random();
    logic [6:0] q[$];
    logic [6:0] held;
    logic [4:0] r;
    logic [3:0] ea, eb;
    logic [1:0] es;
    logic       hold, done;
    int         n_acc, cyc;
    ea = '0; eb = '0; es = '0; hold = 1'b0; done = 1'b0; n_acc = 0; cyc = 0;
    req_valid = 1'b0; rsp_ready = 1'b0;
    while (!done && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      n_vec++;
      if ({alu_s1, alu_s0, alu_a, alu_b} !== {es, ea, eb}) begin
        n_err++; $display("FAIL rnd_alu_in: got %h expected %h", {alu_s1, alu_s0, alu_a, alu_b}, {es, ea, eb});
      end
      if (hold) begin
        n_vec++;
        if ({rsp_valid, rsp_sel, rsp_carry, rsp_result} !== {1'b1, held}) begin
          n_err++; $display("FAIL rnd_stable: got %h expected %h", {rsp_valid, rsp_sel, rsp_carry, rsp_result}, {1'b1, held});
        end
      end
      n_vec++;
      if (busy !== !req_ready) begin n_err++; $display("FAIL rnd_busy: got %b expected %b", busy, !req_ready); end
      if (n_acc == 256 && q.size() == 0) begin
        done = 1'b1;
        req_valid = 1'b0;
      end else begin
        req_valid = (n_acc < 256) && ($urandom_range(0, 3) != 0);
        req_sel   = 2'($urandom);
        req_a     = 4'($urandom);
        req_b     = 4'($urandom);
        rsp_ready = ($urandom_range(0, 2) != 0);
        if (rsp_valid && rsp_ready) begin
          n_vec++;
          if (q.size() == 0) begin
            n_err++; $display("FAIL rnd_spurious: got response %h expected none", {rsp_sel, rsp_carry, rsp_result});
          end else begin
            if ({rsp_sel, rsp_carry, rsp_result} !== q[0]) begin
              n_err++; $display("FAIL rnd_rsp: got %h expected %h", {rsp_sel, rsp_carry, rsp_result}, q[0]);
            end
            void'(q.pop_front());
          end
        end
        if (req_valid && req_ready) begin
          r = alu_ref(req_sel, req_a, req_b);
          q.push_back({req_sel, r});
          es = req_sel; ea = req_a; eb = req_b;
          n_acc++;
        end
        hold = rsp_valid && !rsp_ready;
        held = {rsp_sel, rsp_carry, rsp_result};
      end
    end
    n_vec++;
    if (!done) begin n_err++; $display("FAIL rnd_timeout: got %0d ops done expected 256", n_acc); end
    @(negedge clk);
    n_vec++;
    if ({rsp_valid, op_count} !== {1'b0, 8'(n_acc)}) begin
      n_err++; $display("FAIL rnd_wrap: got %h expected %h", {rsp_valid, op_count}, {1'b0, 8'(n_acc)});
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_sel = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    req_valid3 = 1'b0; req_sel3 = '0; req_a3 = '0; req_b3 = '0; rsp_ready3 = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_settle3();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
